// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared widths, opcode definitions and fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_pkg;

    localparam int          ADDR_WIDTH   = 10;
    localparam int          INSTR_WIDTH  = 12;
    localparam int          OPCODE_WIDTH = 4;
    localparam logic [3:0]  HALT_OPCODE  = 4'hF;

    localparam logic [0:0]  ST_RUN       = 1'b0;
    localparam logic [0:0]  ST_HALTED    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : PC sequencer for a registered-read instruction memory with
//               stall, single-bubble branch redirect and terminal HALT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
    parameter int                    ADDR_WIDTH  = instruction_fetch_pkg::ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = instruction_fetch_pkg::INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]            HALT_OPCODE = instruction_fetch_pkg::HALT_OPCODE
) (
    input  logic                   clk,
    input  logic                   reset_instruction,
    output logic [ADDR_WIDTH-1:0]  instruction_addr_pc,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   fetch_valid,
    output logic [INSTR_WIDTH-1:0] fetch_instr,
    output logic [ADDR_WIDTH-1:0]  fetch_pc,
    output logic                   halted,
    output logic [15:0]            fetch_count
);
    import instruction_fetch_pkg::*;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] out_pc_q;
    logic                  out_valid_q;
    logic [15:0]           fetch_count_q;
    logic                  accept;
    logic                  is_halt;

    assign accept      = fetch_valid && !stall && !branch_taken;
    assign is_halt     = (instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);
    assign fetch_instr = instruction;
    assign fetch_pc    = out_pc_q;
    assign fetch_count = fetch_count_q;

    always_ff @(posedge clk or posedge reset_instruction) begin
        if (reset_instruction) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && accept && is_halt) begin
            state_d = ST_HALTED;
        end
    end

    always_comb begin
        fetch_valid = out_valid_q && (state_q == ST_RUN);
        halted      = (state_q == ST_HALTED);
    end

    // Memory read is registered, so a stall must re-present the address of
    // the word already on the output to keep the data stable next cycle.
    always_comb begin
        instruction_addr_pc = pc_q;
        if (state_q == ST_RUN && branch_taken) begin
            instruction_addr_pc = branch_target;
        end else if (fetch_valid && stall) begin
            instruction_addr_pc = out_pc_q;
        end else if (state_q == ST_HALTED) begin
            instruction_addr_pc = out_pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset_instruction) begin
        if (reset_instruction) begin
            pc_q        <= RESET_PC;
            out_pc_q    <= RESET_PC;
            out_valid_q <= 1'b0;
        end else if (state_q == ST_RUN) begin
            out_pc_q    <= instruction_addr_pc;
            pc_q        <= instruction_addr_pc + ADDR_WIDTH'(1);
            out_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_instruction) begin
        if (reset_instruction) begin
            fetch_count_q <= '0;
        end else if (accept && fetch_count_q != 16'hFFFF) begin
            fetch_count_q <= fetch_count_q + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Randomized scoreboard bench for instruction_fetch against a
//               program-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch;
    logic [9:0]  target;
    logic [11:0] mem [1024];
    logic [11:0] rd1, rd2;

    logic [9:0]  addr1, fpc1, addr2, fpc2;
    logic [11:0] finstr1, finstr2;
    logic        fvalid1, halted1, fvalid2, halted2;
    logic [15:0] fcount1, fcount2;

    always #5 clk = ~clk;

    // Behavioural instruction memory: one-cycle registered read, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            rd1 <= mem[addr1];
            rd2 <= mem[addr2];
        end
    end

    instruction_fetch #(.RESET_PC(10'd0)) dut (
        .clk(clk), .reset_instruction(rst), .instruction_addr_pc(addr1),
        .instruction(rd1), .stall(stall), .branch_taken(branch),
        .branch_target(target), .fetch_valid(fvalid1), .fetch_instr(finstr1),
        .fetch_pc(fpc1), .halted(halted1), .fetch_count(fcount1)
    );

    instruction_fetch #(.RESET_PC(10'd1022)) dut_wrap (
        .clk(clk), .reset_instruction(rst), .instruction_addr_pc(addr2),
        .instruction(rd2), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(10'd0), .fetch_valid(fvalid2), .fetch_instr(finstr2),
        .fetch_pc(fpc2), .halted(halted2), .fetch_count(fcount2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        logic        v;
        logic [9:0]  pc;
        logic [11:0] ins;
        logic        h;
        logic [15:0] cnt;
        logic [9:0]  addr;
    } rec_t;

    rec_t q[$];
    rec_t mon_r;

    // Reference model: where the program stream is, in program-order terms.
    logic        m_valid, m_halted;
    logic [9:0]  m_pc, m_halt_addr;
    logic [15:0] m_count;

    task automatic reset_model();
        m_valid = 1'b0; m_halted = 1'b0; m_pc = 10'd0; m_halt_addr = 10'd0; m_count = 16'd0;
    endtask

    task automatic do_cycle(input logic st, input logic br, input logic [9:0] tg);
        logic [9:0]  a;
        logic [11:0] w;
        rec_t        r;
        stall = st; branch = br; target = tg;
        if (m_halted)            a = m_halt_addr;
        else if (br)             a = tg;
        else if (m_valid && !st) a = m_pc + 10'd1;
        else                     a = m_pc;
        w = mem[m_pc];
        r.v = m_valid; r.pc = m_pc; r.ins = w; r.h = m_halted; r.cnt = m_count; r.addr = a;
        q.push_back(r);
        if (!m_halted && m_valid && !st && !br) begin
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (w[11:8] == 4'hF) begin
                m_halted = 1'b1; m_halt_addr = a; m_valid = 1'b0;
            end
        end
        if (!m_halted) begin
            m_pc = a; m_valid = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        #4;
        if (q.size() > 0) begin
            mon_r = q.pop_front();
            check("fetch_valid", 32'(fvalid1), 32'(mon_r.v));
            check("halted", 32'(halted1), 32'(mon_r.h));
            check("fetch_count", 32'(fcount1), 32'(mon_r.cnt));
            check("instruction_addr_pc", 32'(addr1), 32'(mon_r.addr));
            if (mon_r.v) begin
                check("fetch_pc", 32'(fpc1), 32'(mon_r.pc));
                check("fetch_instr", 32'(finstr1), 32'(mon_r.ins));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(fvalid1), 32'd0);
        check({tag, "_halted"}, 32'(halted1), 32'd0);
        check({tag, "_addr"}, 32'(addr1), 32'd0);
        check({tag, "_pc"}, 32'(fpc1), 32'd0);
        check({tag, "_count"}, 32'(fcount1), 32'd0);
        check({tag, "_instr"}, 32'(finstr1), 32'd0);
    endtask

    initial begin
        logic        st, br;
        logic [9:0]  tg;
        logic [9:0]  wp;
        rst = 1'b1; stall = 1'b0; branch = 1'b0; target = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 12'(i + 1);
        #3;
        check_reset_outputs("reset");
        for (int e = 0; e < 7; e++) begin
            if (e > 0) begin
                for (int i = 0; i < 1024; i++)
                    mem[i] = {4'($urandom_range(0, 14)), 8'($urandom)};
                for (int k = 0; k < 3; k++) mem[$urandom_range(0, 1023)] = 12'hF00;
                if (e == 1) mem[3] = 12'hF00;
            end
            @(negedge clk);
            rst = 1'b0;
            reset_model();
            for (int c = 0; c < (e == 0 ? 16 : 250); c++) begin
                if (c > 0) @(negedge clk);
                if (e == 0 && c >= 1 && c <= 4) begin
                    wp = 10'(1022 + c - 1);
                    check("wrap_fetch_pc", 32'(fpc2), 32'(wp));
                    check("wrap_fetch_instr", 32'(finstr2), 32'(mem[wp]));
                    check("wrap_valid", 32'(fvalid2), 32'd1);
                end
                if (e == 0) begin
                    st = (c >= 3 && c <= 5);
                    br = (c == 9);
                    tg = 10'd500;
                end else begin
                    st = ($urandom_range(0, 4) == 0);
                    br = ($urandom_range(0, 6) == 0);
                    tg = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3))
                                                      : 10'($urandom_range(0, 1023));
                end
                do_cycle(st, br, tg);
            end
            // Asynchronous reset landing mid-cycle while a stall is requested.
            @(negedge clk);
            stall = 1'b1; branch = 1'b0;
            #2 rst = 1'b1;
            #1 check_reset_outputs("async_reset");
            stall = 1'b0;
            @(negedge clk);
        end
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch sequencer driving the address side of the 1024 x 12-bit instruction memory and presenting fetched instructions to decode. Owns the program counter and compensates for the memory's one-cycle registered read latency. Supports downstream stall, single-bubble branch redirect and a terminal HALT state. Sits between `instruction_memory` and the decode/execute stage.

## Interface
- `ADDR_WIDTH`, 10: instruction address width (memory depth 2^ADDR_WIDTH).
- `INSTR_WIDTH`, 12: instruction word width.
- `RESET_PC`, 0: first fetch address after reset.
- `HALT_OPCODE`, 4'hF: value of `instruction[11:8]` that halts fetch.
- `clk` in 1: clock, rising edge.
- `reset_instruction` in 1: reset, asynchronous, active-high (same net that resets instruction memory).
- `instruction_addr_pc` out ADDR_WIDTH: address sampled by instruction memory at each rising edge.
- `instruction` in INSTR_WIDTH: memory read data; equals mem[address sampled at previous edge].
- `stall` in 1: decode not accepting; holds the current fetch output.
- `branch_taken` in 1: redirect request from execute; squashes the current fetch output.
- `branch_target` in ADDR_WIDTH: redirect address, valid with `branch_taken`.
- `fetch_valid` out 1: `fetch_instr`/`fetch_pc` hold a live instruction.
- `fetch_instr` out INSTR_WIDTH: `instruction` passed through.
- `fetch_pc` out ADDR_WIDTH: address of `fetch_instr`.
- `halted` out 1: HALT accepted; fetch frozen until reset.
- `fetch_count` out 16: instructions accepted by decode since reset, saturating at 16'hFFFF.

## Operation
- Registers: `pc_q` (next address to read), `out_pc_q` (address whose data is on `instruction`), `out_valid_q`, state, `fetch_count`.
- States: RUN, HALTED. Reset -> RUN. RUN -> HALTED on HALT accept. HALTED exits only via reset.
- `fetch_valid` = `out_valid_q` and state==RUN. `fetch_pc` = `out_pc_q`. `fetch_instr` = `instruction`.
- Accept = `fetch_valid` and not `stall` and not `branch_taken`.
- `instruction_addr_pc` is a combinational mux, priority order:
  - `branch_taken` (RUN): `branch_target`.
  - `fetch_valid` and `stall`: `out_pc_q` (re-read same word).
  - HALTED: `out_pc_q`.
  - otherwise: `pc_q`.
- Each edge in RUN: `out_pc_q` <= `instruction_addr_pc`; `pc_q` <= `instruction_addr_pc` + 1, modulo 2^ADDR_WIDTH (1023 -> 0); `out_valid_q` <= 1.
- Branch: current output squashed (not counted); target word appears next cycle with `fetch_valid`=1. Penalty: one bubble. `branch_taken` with `fetch_valid`=0 still redirects.
- Stall: outputs held stable (same `fetch_pc`, same data, re-read from memory). `stall` with `fetch_valid`=0 has no effect.
- Branch and stall together: branch wins.
- HALT: accept with `fetch_instr[11:8]`==HALT_OPCODE -> HALTED next edge; `halted`=1, `fetch_valid`=0. HALT under stall waits; HALT squashed by branch is ignored. HALT itself counts as accepted.
- `fetch_count` increments by 1 per accept, saturates.

## Timing
- Reset values: `pc_q`=RESET_PC, `out_pc_q`=RESET_PC, `out_valid_q`=0, state RUN, `fetch_count`=0; so `fetch_valid`=0, `halted`=0, `instruction_addr_pc`=RESET_PC, `fetch_instr`=0 (memory also in reset).
- First edge after reset release: memory reads RESET_PC; `fetch_valid`=1, `fetch_pc`=RESET_PC from that edge on.
- Throughput: 1 instruction/cycle without stall or branch. Address-to-output latency: 1 cycle.
- Reset asserted mid-operation: all registers immediately take reset values, regardless of stall, branch or HALTED.

## Structure
- Shared package (with the opcode definitions): INSTR_WIDTH, ADDR_WIDTH, HALT_OPCODE, state encoding RUN/HALTED.
- Single module; no sub-module. Instantiated alongside `instruction_memory`, sharing `clk` and `reset_instruction`.

## Test plan
- Reset release, memory 0..3 = 12'h001..12'h004, no stall -> `fetch_pc` 0,1,2,3 on consecutive cycles with matching `fetch_instr`; `fetch_count`=4.
- Stall held 3 cycles while `fetch_pc`=2 -> `fetch_pc`=2, `fetch_instr`=12'h003 for 4 cycles, then 3; count unchanged during stall.
- `branch_taken`, `branch_target`=10'd500 while `fetch_pc`=5 -> next cycle `fetch_pc`=500, then 501; word at 5 not counted.
- `RESET_PC`=1022, straight-line code -> `fetch_pc` 1022, 1023, 0, 1.
- mem[3]=12'hF00 -> accepted at `fetch_pc`=3; next cycle `halted`=1, `fetch_valid`=0, `instruction_addr_pc` frozen; branch ignored; reset returns to `fetch_pc`=RESET_PC.
- Branch and stall in same cycle, and HALT squashed by branch -> branch taken, no halt; reset pulsed mid-stall -> outputs at reset values asynchronously.
